reg_scoreboard: RTL



---
 rtl/reg_scoreboard_pkg.sv | 38 +++
 rtl/reg_scoreboard_chk.sv | 13 +
 rtl/reg_scoreboard_cnt_cell.sv | 47 ++++
 rtl/reg_scoreboard.sv | 76 +++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing constants and the saturating up/down counter rule for the
// register write scoreboard.
package reg_scoreboard_pkg;

    localparam int NREG       = 32;
    localparam int CNT_W      = 2;
    localparam int REG_ADDR_W = 5;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             err;
    } sat_res_t;

    // Simultaneous up and down cancel; stepping past either end holds and flags.
    function automatic sat_res_t sat_step(input logic [CNT_W-1:0] cnt,
                                          input logic up, input logic down);
        sat_res_t res;
        res.cnt = cnt;
        res.err = 1'b0;
        case ({up, down})
            2'b10: begin
                if (cnt == CNT_MAX) res.err = 1'b1;
                else                res.cnt = cnt + CNT_ONE;
            end
            2'b01: begin
                if (cnt == CNT_ZERO) res.err = 1'b1;
                else                 res.cnt = cnt - CNT_ONE;
            end
            default: res.err = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_scoreboard_chk.sv
// Upstream protocol checker: ID must not issue while the scoreboard stalls it.
module reg_scoreboard_chk (
    input logic clk,
    input logic rst_n,
    input logic issue_valid,
    input logic stall
);

    a_no_issue_on_stall: assert property (
        @(posedge clk) disable iff (!rst_n) stall |-> !issue_valid
    );

endmodule

// File: rtl/reg_scoreboard_cnt_cell.sv
// One architectural register's outstanding-write and late-write counters,
// with a single-cycle error pulse on overflow, underflow or invariant breach.
module sb_cnt_cell
    import reg_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    input  logic             late_inc,
    input  logic             late_dec,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [CNT_W-1:0] late_cnt,
    output logic             err
);

    logic [CNT_W-1:0] pend_cnt_r;
    logic [CNT_W-1:0] late_cnt_r;
    sat_res_t         pend_res_s;
    sat_res_t         late_res_s;

    assign pend_res_s = sat_step(pend_cnt_r, inc, dec);
    assign late_res_s = sat_step(late_cnt_r, late_inc, late_dec);

    // A retire must never leave more late writes than writes still pending.
    assign err = pend_res_s.err | late_res_s.err
               | (dec & (late_res_s.cnt > pend_res_s.cnt));

    assign pend_cnt = pend_cnt_r;
    assign late_cnt = late_cnt_r;

    // Counter state update; clear overrides all events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt_r <= CNT_ZERO;
            late_cnt_r <= CNT_ZERO;
        end else if (clear) begin
            pend_cnt_r <= CNT_ZERO;
            late_cnt_r <= CNT_ZERO;
        end else begin
            pend_cnt_r <= pend_res_s.cnt;
            late_cnt_r <= late_res_s.cnt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writes from issue to retirement and stalls ID
// when a source operand waits on a result that cannot yet be forwarded.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic                  issue_we_i,
    input  logic [REG_ADDR_W-1:0] issue_waddr_i,
    input  logic                  issue_late_i,
    input  logic                  ready_valid_i,
    input  logic [REG_ADDR_W-1:0] ready_waddr_i,
    input  logic                  retire_valid_i,
    input  logic [REG_ADDR_W-1:0] retire_waddr_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] id_reg1_raddr_i,
    input  logic                  id_reg1_re_i,
    input  logic [REG_ADDR_W-1:0] id_reg2_raddr_i,
    input  logic                  id_reg2_re_i,
    output logic                  sb_stall_o,
    output logic                  sb_busy_o,
    output logic                  sb_err_o
);

    logic             issue_hit_s;
    logic             ready_hit_s;
    logic             retire_hit_s;
    logic [NREG-1:0]  pend_nz_s;
    logic [NREG-1:0]  late_nz_s;
    logic [NREG-1:0]  cell_err_s;
    logic             err_r;

    // Flush discards every event in its cycle, so cells only see clear.
    assign issue_hit_s  = issue_valid_i & issue_we_i & ~flush_i;
    assign ready_hit_s  = ready_valid_i & ~flush_i;
    assign retire_hit_s = retire_valid_i & ~flush_i;

    assign pend_nz_s[0]  = 1'b0;
    assign late_nz_s[0]  = 1'b0;
    assign cell_err_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        localparam logic [REG_ADDR_W-1:0] ADDR = REG_ADDR_W'(r);
        logic [CNT_W-1:0] pend_cnt_s;
        logic [CNT_W-1:0] late_cnt_s;

        sb_cnt_cell u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (flush_i),
            .inc      (issue_hit_s & (issue_waddr_i == ADDR)),
            .dec      (retire_hit_s & (retire_waddr_i == ADDR)),
            .late_inc (issue_hit_s & issue_late_i & (issue_waddr_i == ADDR)),
            .late_dec (ready_hit_s & (ready_waddr_i == ADDR)),
            .pend_cnt (pend_cnt_s),
            .late_cnt (late_cnt_s),
            .err      (cell_err_s[r])
        );

        assign pend_nz_s[r] = |pend_cnt_s;
        assign late_nz_s[r] = |late_cnt_s;
    end

    assign sb_stall_o = (id_reg1_re_i & (id_reg1_raddr_i != '0) & late_nz_s[id_reg1_raddr_i])
                      | (id_reg2_re_i & (id_reg2_raddr_i != '0) & late_nz_s[id_reg2_raddr_i]);
    assign sb_busy_o  = |pend_nz_s;
    assign sb_err_o   = err_r;

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_r <= 1'b0;
        else        err_r <= err_r | (|cell_err_s);
    end

endmodule
